// File: rtl/run_sequencer.sv
// Test-harness sequencer: preloads the core's data memory from a byte stream, holds the
// core in reset for a fixed window, then times the run until done or budget expiry.
module run_sequencer #(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int CW         = 16,
   parameter int MAX_CYCLES = 4096,
   parameter int RST_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [AW-1:0] load_addr,
   input  logic [DW-1:0] load_data,
   input  logic          load_last,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          cpu_reset,
   input  logic          cpu_done,
   output logic          busy,
   output logic          finished,
   output logic          timeout,
   output logic [CW-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RST,
      S_RUN,
      S_DONE,
      S_TIMEOUT
   } state_t;

   localparam int             RCW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LOAD    = RCW'(RST_CYCLES - 1);
   localparam logic [CW-1:0]  CYCLE_LIMIT = CW'(MAX_CYCLES);

   state_t          state, state_d;
   logic [RCW-1:0]  rst_cnt, rst_cnt_d;
   logic            cpu_reset_d;
   logic            mem_we_d;
   logic [AW-1:0]   mem_addr_d;
   logic [DW-1:0]   mem_wdata_d;
   logic            finished_d;
   logic            timeout_d;
   logic [CW-1:0]   cycle_count_d;
   logic            accept;

   // Handshake outputs decode straight from state so they react in the cycle the state changes.
   assign load_ready = (state == S_LOAD);
   assign busy       = (state == S_LOAD) || (state == S_RST) || (state == S_RUN);
   assign accept     = load_valid & load_ready;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state;
      rst_cnt_d     = rst_cnt;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      finished_d    = finished;
      timeout_d     = timeout;
      cycle_count_d = cycle_count;

      unique case (state)
         S_IDLE, S_DONE, S_TIMEOUT: begin
            // cycle_count is left alone so the host can still read the last result.
            if (start) begin
               state_d    = S_LOAD;
               finished_d = 1'b0;
               timeout_d  = 1'b0;
            end
         end

         S_LOAD: begin
            if (accept) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = load_addr;
               mem_wdata_d = load_data;
               if (load_last) begin
                  state_d   = S_RST;
                  rst_cnt_d = RST_LOAD;
               end
            end
         end

         S_RST: begin
            if (rst_cnt == '0) begin
               state_d       = S_RUN;
               cycle_count_d = '0;
            end else begin
               rst_cnt_d = rst_cnt - RCW'(1);
            end
         end

         S_RUN: begin
            cycle_count_d = cycle_count + CW'(1);
            // Done takes priority when it coincides with the final budget cycle.
            if (cpu_done) begin
               state_d    = S_DONE;
               finished_d = 1'b1;
            end else if (cycle_count_d == CYCLE_LIMIT) begin
               state_d   = S_TIMEOUT;
               timeout_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Registered from next state, so the core is frozen on the same edge RUN is left.
      cpu_reset_d = (state_d != S_RUN);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         cpu_reset   <= 1'b1;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         finished    <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
      end else begin
         state       <= state_d;
         rst_cnt     <= rst_cnt_d;
         cpu_reset   <= cpu_reset_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         finished    <= finished_d;
         timeout     <= timeout_d;
         cycle_count <= cycle_count_d;
      end
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: two instances share stimulus, one with a long budget
// (normal completion) and one with MAX_CYCLES = 16 (timeout and done/budget tie).
module tb_run_sequencer;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          load_valid;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;
   logic          load_last;
   logic          cpu_done_a, cpu_done_b;

   logic          load_ready_a, mem_we_a, cpu_reset_a, busy_a, finished_a, timeout_a;
   logic [AW-1:0] mem_addr_a;
   logic [DW-1:0] mem_wdata_a;
   logic [CW-1:0] cycle_count_a;

   logic          load_ready_b, mem_we_b, cpu_reset_b, busy_b, finished_b, timeout_b;
   logic [AW-1:0] mem_addr_b;
   logic [DW-1:0] mem_wdata_b;
   logic [CW-1:0] cycle_count_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   run_sequencer #(.AW(AW), .DW(DW), .CW(CW), .MAX_CYCLES(4096), .RST_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .start(start),
      .load_valid(load_valid), .load_ready(load_ready_a),
      .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .cpu_reset(cpu_reset_a), .cpu_done(cpu_done_a), .busy(busy_a),
      .finished(finished_a), .timeout(timeout_a), .cycle_count(cycle_count_a)
   );

   run_sequencer #(.AW(AW), .DW(DW), .CW(CW), .MAX_CYCLES(16), .RST_CYCLES(2)) dut_b (
      .clk(clk), .reset(reset), .start(start),
      .load_valid(load_valid), .load_ready(load_ready_b),
      .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .cpu_reset(cpu_reset_b), .cpu_done(cpu_done_b), .busy(busy_b),
      .finished(finished_b), .timeout(timeout_b), .cycle_count(cycle_count_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it; all drives and checks happen here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_word(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic l);
      load_valid = v;
      load_addr  = a;
      load_data  = d;
      load_last  = l;
   endtask

   task automatic check_reset_values_a(input string tag);
      check({tag, ".state_idle_busy"}, 32'(busy_a), 32'd0);
      check({tag, ".load_ready"}, 32'(load_ready_a), 32'd0);
      check({tag, ".cpu_reset"}, 32'(cpu_reset_a), 32'd1);
      check({tag, ".mem_we"}, 32'(mem_we_a), 32'd0);
      check({tag, ".mem_addr"}, 32'(mem_addr_a), 32'd0);
      check({tag, ".mem_wdata"}, 32'(mem_wdata_a), 32'd0);
      check({tag, ".finished"}, 32'(finished_a), 32'd0);
      check({tag, ".timeout"}, 32'(timeout_a), 32'd0);
      check({tag, ".cycle_count"}, 32'(cycle_count_a), 32'd0);
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      cpu_done_a = 1'b0;
      cpu_done_b = 1'b0;
      drive_word(1'b0, 8'h00, 8'h00, 1'b0);

      // Reset state
      #12;
      check_reset_values_a("rst");
      reset = 1'b1;
      tick();
      check("idle_hold.busy", 32'(busy_a), 32'd0);
      check("idle_hold.cpu_reset", 32'(cpu_reset_a), 32'd1);

      // Preload three words with load_valid held high
      start = 1'b1;
      tick();
      check("start.load_ready", 32'(load_ready_a), 32'd1);
      check("start.busy", 32'(busy_a), 32'd1);
      check("start.cpu_reset", 32'(cpu_reset_a), 32'd1);
      start = 1'b0;
      drive_word(1'b1, 8'h00, 8'h11, 1'b0);
      tick();
      check("pre0.we", 32'(mem_we_a), 32'd1);
      check("pre0.addr", 32'(mem_addr_a), 32'h00);
      check("pre0.data", 32'(mem_wdata_a), 32'h11);
      drive_word(1'b1, 8'h01, 8'h22, 1'b0);
      tick();
      check("pre1.we", 32'(mem_we_a), 32'd1);
      check("pre1.addr", 32'(mem_addr_a), 32'h01);
      check("pre1.data", 32'(mem_wdata_a), 32'h22);
      drive_word(1'b1, 8'h80, 8'h33, 1'b1);
      tick();
      check("pre2.we", 32'(mem_we_a), 32'd1);
      check("pre2.addr", 32'(mem_addr_a), 32'h80);
      check("pre2.data", 32'(mem_wdata_a), 32'h33);
      check("pre2.load_ready", 32'(load_ready_a), 32'd0);
      check("pre2.cpu_reset", 32'(cpu_reset_a), 32'd1);
      drive_word(1'b0, 8'hEE, 8'hEE, 1'b0);
      tick();
      check("rst1.we", 32'(mem_we_a), 32'd0);
      check("rst1.addr_hold", 32'(mem_addr_a), 32'h80);
      check("rst1.cpu_reset", 32'(cpu_reset_a), 32'd1);
      tick();
      check("run_entry.cpu_reset", 32'(cpu_reset_a), 32'd0);
      check("run_entry.busy", 32'(busy_a), 32'd1);
      check("run_entry.count", 32'(cycle_count_a), 32'd0);
      check("run_entry_b.cpu_reset", 32'(cpu_reset_b), 32'd0);

      // RUN: A completes on cycle 37, B times out after 16; start pulses early have no effect
      for (int n = 1; n <= 40; n++) begin
         cpu_done_a = (n == 37);
         start      = (n >= 5 && n <= 10);
         tick();
         if (n == 10) begin
            check("run10.busy", 32'(busy_a), 32'd1);
            check("run10.cpu_reset", 32'(cpu_reset_a), 32'd0);
            check("run10.count", 32'(cycle_count_a), 32'd10);
            check("run10.load_ready", 32'(load_ready_a), 32'd0);
         end
         if (n == 15) begin
            check("b15.timeout", 32'(timeout_b), 32'd0);
            check("b15.count", 32'(cycle_count_b), 32'd15);
         end
         if (n == 16) begin
            check("b16.timeout", 32'(timeout_b), 32'd1);
            check("b16.finished", 32'(finished_b), 32'd0);
            check("b16.count", 32'(cycle_count_b), 32'd16);
            check("b16.cpu_reset", 32'(cpu_reset_b), 32'd1);
            check("b16.busy", 32'(busy_b), 32'd0);
         end
         if (n == 36) check("a36.finished", 32'(finished_a), 32'd0);
         if (n == 37) begin
            check("a37.finished", 32'(finished_a), 32'd1);
            check("a37.count", 32'(cycle_count_a), 32'd37);
            check("a37.timeout", 32'(timeout_a), 32'd0);
            check("a37.cpu_reset", 32'(cpu_reset_a), 32'd1);
            check("a37.busy", 32'(busy_a), 32'd0);
         end
      end
      check("a_hold.count", 32'(cycle_count_a), 32'd37);
      check("b_hold.count", 32'(cycle_count_b), 32'd16);
      check("b_hold.timeout", 32'(timeout_b), 32'd1);

      // Restart from DONE / TIMEOUT, then a stalled loader (valid 1,0,0,1)
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart.finished", 32'(finished_a), 32'd0);
      check("restart.load_ready", 32'(load_ready_a), 32'd1);
      check("restart.count_hold", 32'(cycle_count_a), 32'd37);
      check("restart_b.timeout", 32'(timeout_b), 32'd0);
      check("restart_b.count_hold", 32'(cycle_count_b), 32'd16);
      drive_word(1'b1, 8'h05, 8'hA5, 1'b0);
      tick();
      check("stall0.we", 32'(mem_we_a), 32'd1);
      check("stall0.addr", 32'(mem_addr_a), 32'h05);
      check("stall0.data", 32'(mem_wdata_a), 32'hA5);
      drive_word(1'b0, 8'h77, 8'h66, 1'b1);
      tick();
      check("stall1.we", 32'(mem_we_a), 32'd0);
      check("stall1.addr", 32'(mem_addr_a), 32'h05);
      check("stall1.data", 32'(mem_wdata_a), 32'hA5);
      tick();
      check("stall2.we", 32'(mem_we_a), 32'd0);
      check("stall2.data", 32'(mem_wdata_a), 32'hA5);
      check("stall2.load_ready", 32'(load_ready_a), 32'd1);
      drive_word(1'b1, 8'h06, 8'h5A, 1'b1);
      tick();
      check("stall3.we", 32'(mem_we_a), 32'd1);
      check("stall3.addr", 32'(mem_addr_a), 32'h06);
      check("stall3.data", 32'(mem_wdata_a), 32'h5A);
      drive_word(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      check("rst_b.count_hold", 32'(cycle_count_a), 32'd37);
      tick();
      check("run2.count", 32'(cycle_count_a), 32'd0);
      check("run2.cpu_reset", 32'(cpu_reset_a), 32'd0);

      // Done coinciding with the final budget cycle on B; A finishes on cycle 3
      for (int n = 1; n <= 16; n++) begin
         cpu_done_a = (n == 3);
         cpu_done_b = (n == 16);
         tick();
         if (n == 3) check("a3.count", 32'(cycle_count_a), 32'd3);
      end
      cpu_done_a = 1'b0;
      cpu_done_b = 1'b0;
      check("tie.finished", 32'(finished_b), 32'd1);
      check("tie.timeout", 32'(timeout_b), 32'd0);
      check("tie.count", 32'(cycle_count_b), 32'd16);
      check("a3.finished", 32'(finished_a), 32'd1);

      // Asynchronous reset in the middle of a RUN cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      drive_word(1'b1, 8'h10, 8'h99, 1'b1);
      tick();
      drive_word(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      tick();
      tick();
      check("pre_arst.cpu_reset", 32'(cpu_reset_a), 32'd0);
      check("pre_arst.count", 32'(cycle_count_a), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check_reset_values_a("arst");
      check("arst_b.cpu_reset", 32'(cpu_reset_b), 32'd1);
      #1;
      reset = 1'b1;
      tick();
      check("post_arst.busy", 32'(busy_a), 32'd0);
      check("post_arst.cpu_reset", 32'(cpu_reset_a), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Test-harness sequencer that sits directly upstream of the 9-bit-instruction core. It preloads the core's data memory through a byte-stream handshake and holds the core in reset for a fixed window. It then releases the core and counts execution cycles until the core raises `done` or a cycle budget expires, and reports the outcome to the bench or host.

## Interface
Parameters:
- `AW`, 8, data-memory address width
- `DW`, 8, data-memory word width
- `CW`, 16, cycle-counter width
- `MAX_CYCLES`, 4096, RUN-cycle budget; must satisfy 1 ≤ MAX_CYCLES ≤ 2^CW−1
- `RST_CYCLES`, 2, cycles the core is held in reset after preload; must be ≥ 1

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled only in IDLE, DONE and TIMEOUT
- `load_valid`  in  1  preload word offered
- `load_ready`  out  1  sequencer accepts a preload word
- `load_addr`  in  AW  preload address
- `load_data`  in  DW  preload data
- `load_last`  in  1  qualifies the final preload word
- `mem_we`  out  1  data-memory write strobe to the core's memory preload port
- `mem_addr`  out  AW  data-memory write address
- `mem_wdata`  out  DW  data-memory write data
- `cpu_reset`  out  1  active-high reset to the core
- `cpu_done`  in  1  core `done` output
- `busy`  out  1  high in LOAD, RST and RUN
- `finished`  out  1  run ended by `cpu_done`
- `timeout`  out  1  run ended by budget expiry
- `cycle_count`  out  CW  RUN cycles of the last or current run

## Operation
- States: IDLE, LOAD, RST, RUN, DONE, TIMEOUT. All outputs are registered except `load_ready` and `busy`, which decode from state only.
- **Reset values** (`reset` = 0): state IDLE, `cpu_reset` = 1, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `finished` = 0, `timeout` = 0, `cycle_count` = 0, RST counter = 0. `load_ready` and `busy` are 0 in IDLE.
- **Core reset control:** `cpu_reset` is 1 in every state except RUN. The core is therefore frozen in DONE and TIMEOUT.
- **IDLE / DONE / TIMEOUT:** `start` = 1 moves to LOAD. The move clears `finished` and `timeout`. `cycle_count` holds until RUN is entered.
- **LOAD:**
  - `load_ready` = 1.
  - Accept = `load_valid` & `load_ready` at an edge.
  - On accept, `mem_we` ← 1, `mem_addr` ← `load_addr`, `mem_wdata` ← `load_data`.
  - When there is no accept, `mem_we` ← 0 and `mem_addr`/`mem_wdata` hold.
  - Accept with `load_last` = 1 moves to RST and loads the RST counter with RST_CYCLES−1.
  - Duplicate addresses are written in arrival order; the last write wins.
- **RST:** the RST counter decrements each cycle. When the counter is 0, the state moves to RUN and `cycle_count` ← 0.
- **RUN:**
  - On every edge, `cycle_count` ← `cycle_count` + 1.
  - If `cpu_done` = 1, move to DONE and set `finished` ← 1.
  - Otherwise, if `cycle_count` + 1 == MAX_CYCLES, move to TIMEOUT and set `timeout` ← 1.
  - When `cpu_done` and the budget limit occur on the same edge, `cpu_done` wins.
  - The final `cycle_count` equals the number of RUN cycles, including the cycle in which `cpu_done` was sampled.
- `cpu_done` is ignored outside RUN. `start` is ignored in LOAD, RST and RUN.
- **Reset mid-operation:** an asynchronous return to the reset values. The partial preload already written to memory is not undone.

## Timing
- `start` sampled at edge t: state is LOAD and `load_ready` = 1 from t+.
- Accept at edge k: `mem_we` = 1 with the captured address and data during cycle k..k+1. Write latency is 1 cycle.
- Back-to-back accepts produce back-to-back `mem_we` pulses. Throughput is 1 word per cycle.
- Last accept at edge k:
  - `cpu_reset` stays 1 through edge k+RST_CYCLES.
  - RUN is entered at k+RST_CYCLES, where `cpu_reset` falls to 0.
  - The final `mem_we` pulse (cycle k..k+1) always completes before `cpu_reset` falls.
- `cpu_done` sampled at a RUN edge: `finished` = 1 and `cpu_reset` = 1 from that edge. `busy` falls in the same cycle.
- Maximum RUN length is MAX_CYCLES cycles. On timeout, `cycle_count` = MAX_CYCLES.

## Test plan
- **Async reset:** pulse `reset` low mid-cycle while in RUN → all outputs take their reset values immediately, without waiting for a clock edge; state is IDLE; `cpu_reset` = 1.
- **Preload:** `start`, then 3 words (0x00←0x11, 0x01←0x22, 0x80←0x33, last on the third) with `load_valid` held → three consecutive `mem_we` pulses, each one cycle after its accept, with matching addr/data. `cpu_reset` falls exactly RST_CYCLES = 2 edges after the last accept.
- **Stalled loader:** `load_valid` toggled 1,0,0,1 → `mem_we` pulses only after accepting edges; `mem_addr` and `mem_wdata` hold in between.
- **Normal completion:** a model core raises `cpu_done` on its 37th RUN cycle → `finished` = 1, `cycle_count` = 37, `timeout` = 0, `cpu_reset` = 1, `busy` = 0.
- **Timeout:** MAX_CYCLES = 16, `cpu_done` never asserted → `timeout` = 1 after exactly 16 RUN cycles, `cycle_count` = 16. A simultaneous `cpu_done` on cycle 16 instead gives `finished` = 1, `timeout` = 0.
- **Restart:** `start` in DONE → `finished` clears and `load_ready` = 1 the next cycle. `cycle_count` holds 37 until RUN, then restarts from 0. `start` held during RUN has no effect.
